// File: rtl/mpeg2_mem_pkg.sv
// Shared definitions for the mpeg2video framebuffer memory responder:
// request commands, FSM states and the response FIFO slack limit.
package mpeg2_mem_pkg;

    typedef enum logic [1:0] {
        CMD_NOOP    = 2'd0,
        CMD_REFRESH = 2'd1,
        CMD_READ    = 2'd2,
        CMD_WRITE   = 2'd3
    } mem_cmd_e;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_REFRESH = 1'b1
    } resp_state_e;

    // Words the decoder response FIFO can still absorb once almost_full rises.
    localparam int RESP_FIFO_SLACK = 16;

    function automatic logic latency_ok(input int lat);
        return (lat >= 1) && (lat <= RESP_FIFO_SLACK);
    endfunction

endpackage

// File: rtl/mpeg2_mem_ram.sv
// Single-port synchronous RAM with registered read data. Contents are never
// reset; only the read register is cleared.
module mpeg2_mem_ram #(
    parameter int AW = 16,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [2**AW];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= {DW{1'b0}};
        end else if (re) begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/mpeg2_mem_responder.sv
// Memory responder for the mpeg2video framebuffer port: pops the show-ahead
// request FIFO, services commands against a RAM, returns reads at fixed latency.
module mpeg2_mem_responder
    import mpeg2_mem_pkg::*;
#(
    parameter int ADDR_W         = 22,
    parameter int DATA_W         = 64,
    parameter int MEM_AW         = 16,
    parameter int READ_LATENCY   = 4,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic              mem_clk,
    input  logic              rst,
    input  logic [1:0]        mem_req_rd_cmd,
    input  logic [ADDR_W-1:0] mem_req_rd_addr,
    input  logic [DATA_W-1:0] mem_req_rd_dta,
    input  logic              mem_req_rd_valid,
    output logic              mem_req_rd_en,
    output logic [DATA_W-1:0] mem_res_wr_dta,
    output logic              mem_res_wr_en,
    input  logic              mem_res_wr_almost_full,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REFRESH_CYCLES - 1);

    if (!latency_ok(READ_LATENCY) || (REFRESH_CYCLES < 1)) begin : g_param_check
        $error("mpeg2_mem_responder: READ_LATENCY or REFRESH_CYCLES out of range");
    end

    resp_state_e           state_r, state_s;
    logic [CNT_W-1:0]      ref_cnt_r, ref_cnt_s;
    mem_cmd_e              cmd_s;
    logic                  accept_s, acc_rd_s, acc_wr_s;
    logic [READ_LATENCY-1:0] vld_r;
    logic [DATA_W-1:0]     ram_q_s;
    logic                  addr_hi_unused_s;

    assign addr_hi_unused_s = ^mem_req_rd_addr[ADDR_W-1:MEM_AW];

    // Accept decode: a read stalled by almost_full blocks the whole queue.
    always_comb begin
        cmd_s    = mem_cmd_e'(mem_req_rd_cmd);
        accept_s = (state_r == S_IDLE) && mem_req_rd_valid && !rst &&
                   !((cmd_s == CMD_READ) && mem_res_wr_almost_full);
        acc_rd_s = accept_s && (cmd_s == CMD_READ);
        acc_wr_s = accept_s && (cmd_s == CMD_WRITE);
        mem_req_rd_en = accept_s;
    end

    // Next-state logic for the refresh busy window.
    always_comb begin
        state_s   = state_r;
        ref_cnt_s = ref_cnt_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && (cmd_s == CMD_REFRESH)) begin
                    state_s   = S_REFRESH;
                    ref_cnt_s = CNT_LOAD;
                end else begin
                    state_s   = S_IDLE;
                    ref_cnt_s = ref_cnt_r;
                end
            end
            S_REFRESH: begin
                if (ref_cnt_r == {CNT_W{1'b0}}) begin
                    state_s   = S_IDLE;
                    ref_cnt_s = ref_cnt_r;
                end else begin
                    state_s   = S_REFRESH;
                    ref_cnt_s = ref_cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s   = S_IDLE;
                ref_cnt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            ref_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            ref_cnt_r <= ref_cnt_s;
        end
    end

    // Accepted-command counters, wrapping modulo 2**32.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else begin
            if (acc_rd_s) begin
                rd_count <= rd_count + 32'd1;
            end
            if (acc_wr_s) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end

    // Read valid pipeline; stage 0 lines up with the RAM's registered output.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            vld_r <= {READ_LATENCY{1'b0}};
        end else begin
            vld_r[0] <= acc_rd_s;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_r[k] <= vld_r[k-1];
            end
        end
    end

    assign mem_res_wr_en = vld_r[READ_LATENCY-1];

    mpeg2_mem_ram #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_ram (
        .clk   (mem_clk),
        .rst   (rst),
        .we    (acc_wr_s),
        .re    (acc_rd_s),
        .addr  (mem_req_rd_addr[MEM_AW-1:0]),
        .wdata (mem_req_rd_dta),
        .rdata (ram_q_s)
    );

    if (READ_LATENCY == 1) begin : g_no_delay
        assign mem_res_wr_dta = ram_q_s;
    end else begin : g_delay
        logic [DATA_W-1:0] dly_r [READ_LATENCY-1];

        // Data delay line padding the RAM read out to the full latency.
        always_ff @(posedge mem_clk) begin
            if (rst) begin
                for (int k = 0; k < READ_LATENCY - 1; k++) begin
                    dly_r[k] <= {DATA_W{1'b0}};
                end
            end else begin
                dly_r[0] <= ram_q_s;
                for (int k = 1; k < READ_LATENCY - 1; k++) begin
                    dly_r[k] <= dly_r[k-1];
                end
            end
        end

        assign mem_res_wr_dta = dly_r[READ_LATENCY-2];
    end

endmodule

// File: tb/tb_mpeg2_mem_responder.sv
// Directed bench for mpeg2_mem_responder: emulates the show-ahead request FIFO
// and logs pops and responses per cycle, then checks them against hand values.
module tb_mpeg2_mem_responder;
    import mpeg2_mem_pkg::*;

    logic        mem_clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mem_req_rd_cmd = 2'd0;
    logic [21:0] mem_req_rd_addr = 22'd0;
    logic [63:0] mem_req_rd_dta = 64'd0;
    logic        mem_req_rd_valid = 1'b0;
    logic        mem_req_rd_en;
    logic [63:0] mem_res_wr_dta;
    logic        mem_res_wr_en;
    logic        mem_res_wr_almost_full = 1'b0;
    logic [31:0] rd_count, wr_count;

    mpeg2_mem_responder dut (
        .mem_clk                (mem_clk),
        .rst                    (rst),
        .mem_req_rd_cmd         (mem_req_rd_cmd),
        .mem_req_rd_addr        (mem_req_rd_addr),
        .mem_req_rd_dta         (mem_req_rd_dta),
        .mem_req_rd_valid       (mem_req_rd_valid),
        .mem_req_rd_en          (mem_req_rd_en),
        .mem_res_wr_dta         (mem_res_wr_dta),
        .mem_res_wr_en          (mem_res_wr_en),
        .mem_res_wr_almost_full (mem_res_wr_almost_full),
        .rd_count               (rd_count),
        .wr_count               (wr_count)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct { logic [1:0] cmd; logic [21:0] addr; logic [63:0] dta; } req_t;
    typedef struct { int cyc; logic [63:0] d; } ev_t;

    req_t req_q[$];
    ev_t  acc_q[$];
    ev_t  rsp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic af = 1'b0;
    logic rst_cmd = 1'b1;
    int   s;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] c, input logic [21:0] a, input logic [63:0] d);
        req_t r;
        r.cmd = c; r.addr = a; r.dta = d;
        req_q.push_back(r);
    endtask

    task automatic clr();
        acc_q.delete();
        rsp_q.delete();
    endtask

    // One clock: drive FIFO head at negedge, sample just after, pop on rd_en.
    task automatic tick();
        ev_t e;
        @(negedge mem_clk);
        rst = rst_cmd;
        mem_res_wr_almost_full = af;
        if (req_q.size() > 0) begin
            mem_req_rd_valid = 1'b1;
            mem_req_rd_cmd   = req_q[0].cmd;
            mem_req_rd_addr  = req_q[0].addr;
            mem_req_rd_dta   = req_q[0].dta;
        end else begin
            mem_req_rd_valid = 1'b0;
            mem_req_rd_cmd   = 2'd0;
            mem_req_rd_addr  = 22'd0;
            mem_req_rd_dta   = 64'd0;
        end
        #1;
        if (mem_req_rd_en) begin
            e.cyc = cyc;
            e.d   = 64'(mem_req_rd_cmd);
            acc_q.push_back(e);
            if (req_q.size() > 0) void'(req_q.pop_front());
        end
        if (mem_res_wr_en) begin
            e.cyc = cyc;
            e.d   = mem_res_wr_dta;
            rsp_q.push_back(e);
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        // Reset: a queued command must not be popped while rst is high.
        rst_cmd = 1'b1;
        push(CMD_READ, 22'h000001, 64'd0);
        run(3);
        chk("rst_no_pop", 64'(acc_q.size()), 64'd0);
        chk("rst_res_en", 64'(mem_res_wr_en), 64'd0);
        chk("rst_res_dta", mem_res_wr_dta, 64'd0);
        chk("rst_rd_count", 64'(rd_count), 64'd0);
        chk("rst_wr_count", 64'(wr_count), 64'd0);
        req_q.delete();
        rst_cmd = 1'b0;
        run(1);
        clr();

        // Write then read of the same address in the next cycle.
        s = cyc;
        push(CMD_WRITE, 22'h000010, 64'h0123456789ABCDEF);
        push(CMD_READ,  22'h000010, 64'd0);
        run(10);
        chk("t1_acc_n", 64'(acc_q.size()), 64'd2);
        chk("t1_wr_cyc", 64'(acc_q[0].cyc - s), 64'd0);
        chk("t1_rd_cyc", 64'(acc_q[1].cyc - s), 64'd1);
        chk("t1_rsp_n", 64'(rsp_q.size()), 64'd1);
        chk("t1_rsp_lat", 64'(rsp_q[0].cyc - s), 64'd5);
        chk("t1_rsp_dta", rsp_q[0].d, 64'h0123456789ABCDEF);
        chk("t1_wr_count", 64'(wr_count), 64'd1);
        chk("t1_rd_count", 64'(rd_count), 64'd1);

        // Eight back-to-back reads of preloaded words.
        clr();
        s = cyc;
        for (int i = 0; i < 8; i++) push(CMD_WRITE, 22'(i), 64'(i * 17));
        for (int i = 0; i < 8; i++) push(CMD_READ, 22'(i), 64'd0);
        run(30);
        chk("t2_acc_n", 64'(acc_q.size()), 64'd16);
        chk("t2_last_acc", 64'(acc_q[15].cyc - s), 64'd15);
        chk("t2_rsp_n", 64'(rsp_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_dta%0d", i), rsp_q[i].d, 64'(i * 17));
            chk($sformatf("t2_cyc%0d", i), 64'(rsp_q[i].cyc - s), 64'(12 + i));
        end
        chk("t2_rd_count", 64'(rd_count), 64'd9);

        // Refresh holds off the following read for eight cycles.
        clr();
        s = cyc;
        push(CMD_REFRESH, 22'd0, 64'd0);
        push(CMD_READ, 22'h000003, 64'd0);
        run(16);
        chk("t3_acc_n", 64'(acc_q.size()), 64'd2);
        chk("t3_ref_cyc", 64'(acc_q[0].cyc - s), 64'd0);
        chk("t3_rd_cyc", 64'(acc_q[1].cyc - s), 64'd9);
        chk("t3_rsp_dta", rsp_q[0].d, 64'h33);
        chk("t3_rsp_cyc", 64'(rsp_q[0].cyc - s), 64'd13);

        // almost_full blocks a read and the write queued behind it.
        clr();
        af = 1'b1;
        push(CMD_READ, 22'h000010, 64'd0);
        push(CMD_WRITE, 22'h000020, 64'hA5A5A5A55A5A5A5A);
        run(5);
        chk("t4_blocked", 64'(acc_q.size()), 64'd0);
        af = 1'b0;
        s = cyc;
        run(8);
        chk("t4_acc_n", 64'(acc_q.size()), 64'd2);
        chk("t4_first_cmd", acc_q[0].d, 64'(CMD_READ));
        chk("t4_first_cyc", 64'(acc_q[0].cyc - s), 64'd0);
        chk("t4_second_cmd", acc_q[1].d, 64'(CMD_WRITE));
        chk("t4_second_cyc", 64'(acc_q[1].cyc - s), 64'd1);
        chk("t4_rsp_dta", rsp_q[0].d, 64'h0123456789ABCDEF);
        chk("t4_rsp_cyc", 64'(rsp_q[0].cyc - s), 64'd4);

        // Upper address bits alias onto the implemented depth.
        clr();
        push(CMD_WRITE, 22'h010005, 64'hDEADBEEFCAFEF00D);
        push(CMD_READ,  22'h000005, 64'd0);
        run(8);
        chk("t5_rsp_n", 64'(rsp_q.size()), 64'd1);
        chk("t5_alias_dta", rsp_q[0].d, 64'hDEADBEEFCAFEF00D);

        // Reset with three reads in flight discards them; RAM survives.
        clr();
        push(CMD_READ, 22'd0, 64'd0);
        push(CMD_READ, 22'd1, 64'd0);
        push(CMD_READ, 22'd2, 64'd0);
        run(3);
        chk("t6_acc_n", 64'(acc_q.size()), 64'd3);
        clr();
        rst_cmd = 1'b1;
        run(1);
        rst_cmd = 1'b0;
        run(10);
        chk("t6_no_rsp", 64'(rsp_q.size()), 64'd0);
        chk("t6_rd_count", 64'(rd_count), 64'd0);
        chk("t6_wr_count", 64'(wr_count), 64'd0);
        push(CMD_READ, 22'h000010, 64'd0);
        push(CMD_READ, 22'h000020, 64'd0);
        run(8);
        chk("t6_rsp_n", 64'(rsp_q.size()), 64'd2);
        chk("t6_dta0", rsp_q[0].d, 64'h0123456789ABCDEF);
        chk("t6_dta1", rsp_q[1].d, 64'hA5A5A5A55A5A5A5A);
        chk("t6_rd_count2", 64'(rd_count), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mpeg2_mem_responder.md
Name: mpeg2_mem_responder

Overview:
Simulation-side memory responder for the mpeg2video decoder's framebuffer port. It is the other end of the decoder's mem_req / mem_res FIFO interface, and it has these jobs:
- consume commands from the decoder's show-ahead request FIFO;
- service them against an inferred 64-bit RAM;
- push read data into the decoder's response FIFO with fixed, SDRAM-like latency.

It sits beside mpeg2video in the sim top, in the mem_clk domain.

Parameters:
ADDR_W, 22, width of mem_req_rd_addr (decoder word address)
DATA_W, 64, width of request write data and response read data
MEM_AW, 16, implemented RAM depth is 2**MEM_AW words; address bits above MEM_AW-1 are ignored (aliasing)
READ_LATENCY, 4, cycles from read acceptance to mem_res_wr_en; legal range 1..16
REFRESH_CYCLES, 8, cycles the responder stays busy after accepting CMD_REFRESH; must be >= 1

Ports:
mem_clk  in  1  memory clock; all logic on its rising edge
rst  in  1  synchronous active-high reset
mem_req_rd_cmd  in  2  head-of-FIFO command
mem_req_rd_addr  in  ADDR_W  head-of-FIFO address
mem_req_rd_dta  in  DATA_W  head-of-FIFO write data
mem_req_rd_valid  in  1  request FIFO non-empty; head fields valid
mem_req_rd_en  out  1  pop strobe; the head is consumed in the same cycle
mem_res_wr_dta  out  DATA_W  read response data
mem_res_wr_en  out  1  push strobe into the decoder response FIFO
mem_res_wr_almost_full  in  1  response FIFO cannot take more than 16 further words
rd_count  out  32  number of CMD_READ commands accepted since reset
wr_count  out  32  number of CMD_WRITE commands accepted since reset

Behaviour:
- Commands (from the package): CMD_NOOP=0, CMD_REFRESH=1, CMD_READ=2, CMD_WRITE=3.
- Reset values: mem_req_rd_en=0, mem_res_wr_en=0, mem_res_wr_dta=0, rd_count=0, wr_count=0. State=S_IDLE, refresh counter=0, in-flight pipeline cleared.
- Reset does not clear RAM contents. A reset asserted mid-operation discards all in-flight reads; no mem_res_wr_en is produced for them after rst deasserts.
- States are S_IDLE and S_REFRESH.
- Accept condition (combinational): state==S_IDLE && mem_req_rd_valid && !rst && !(cmd==CMD_READ && mem_res_wr_almost_full). Under this condition mem_req_rd_en=1.
- Head-of-line blocking: a read blocked by almost_full also holds back every later command. Order is strictly preserved.
- CMD_NOOP: popped; no other effect.
- CMD_WRITE: RAM[addr[MEM_AW-1:0]] <= dta at the end of the accept cycle. wr_count increments. A read accepted in the next cycle to the same address returns the new data.
- CMD_READ: address is latched into a valid/address pipeline. rd_count increments.
  - Read data is registered by the RAM sub-module (1 cycle), then delayed to a total of READ_LATENCY cycles.
  - If accepted in cycle t: mem_res_wr_en=1 with the data in cycle t+READ_LATENCY, for exactly 1 cycle.
  - Back-to-back reads give back-to-back responses, one per cycle, in order.
  - Data reflects RAM at acceptance. A write accepted after the read does not alter the in-flight result.
- CMD_REFRESH: popped; state goes to S_REFRESH with the counter loaded to REFRESH_CYCLES-1.
  - In S_REFRESH, the counter decrements each cycle; no command is accepted.
  - When the counter reaches 0, state returns to S_IDLE on the next edge. Total busy = REFRESH_CYCLES cycles after the accept cycle.
  - In-flight reads keep draining during refresh.
- almost_full dropping while reads are in flight does not affect them. Responses are never held back; the FIFO's 16-word slack covers READ_LATENCY<=16.
- Counters wrap modulo 2**32.
- Valid low: mem_req_rd_en=0; the pipeline still advances.

Decomposition:
- Package mpeg2_mem_pkg holds:
  - the 2-bit command typedef and CMD_* constants;
  - the response-FIFO slack constant (16), used to check READ_LATENCY.
- Sub-module mpeg2_mem_ram: single-port synchronous RAM with DEPTH=2**MEM_AW, width DATA_W, write-enable and registered read data.
- Top-level FSM, latency pipeline and counters live in mpeg2_mem_responder.

Test Plan:
- WRITE addr 0x000010 dta 0x0123456789ABCDEF, then READ 0x000010 next cycle -> mem_res_wr_en pulses 4 cycles after read accept with 0x0123456789ABCDEF; wr_count=1, rd_count=1.
- 8 back-to-back READs of addresses 0..7 preloaded with values i*0x11 -> 8 consecutive mem_res_wr_en pulses, data 0x00..0x77 in order, first at t+4.
- REFRESH followed by READ, both queued -> rd_en high for REFRESH, low for 8 cycles, READ accepted on the 9th cycle after.
- almost_full=1 with a READ at head and a WRITE behind it -> no pops. Drop almost_full -> READ popped, then WRITE next cycle.
- Alias check: WRITE 0x010005 (MEM_AW=16), then READ 0x000005 -> same data returned.
- rst for 1 cycle while 3 reads in flight -> zero mem_res_wr_en afterwards; counters 0; prior RAM contents readable.
